// File: rtl/reg_dump_reader.sv
// Sequential register-file dumper: walks addresses lo..hi through one read port and
// streams (address, data) beats on a valid/ready channel. Define REG_DUMP_CHECKSUM_EN to build the checksum adder.
module reg_dump_reader #(
  parameter int n = 5,
  parameter int m = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] lo,
  input  logic [n-1:0] hi,
  output logic [n-1:0] A1,
  input  logic [m-1:0] RD1,
  output logic [n-1:0] dout_addr,
  output logic [m-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t       state;
  logic [n-1:0] addr;
  logic [n-1:0] end_addr;
  logic         fire;
  logic         accept;

  assign A1         = addr;
  assign dout_valid = (state == HOLD);
  assign fire       = dout_valid & dout_ready;
  assign accept     = (state == IDLE) & start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      end_addr  <= '0;
      dout      <= '0;
      dout_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr     <= lo;
            end_addr <= hi;
            busy     <= 1'b1;
            if (lo <= hi) begin
              state <= READ;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          dout      <= RD1;
          dout_addr <= addr;
          state     <= HOLD;
        end
        HOLD: begin
          // Compare before increment so hi = 2^n-1 never wraps addr back to 0.
          if (fire) begin
            if (addr == end_addr) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              addr  <= addr + n'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [m-1:0] sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (accept) begin
      sum <= '0;
    end else if (fire) begin
      sum <= sum + dout;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed scoreboard bench for reg_dump_reader: expected beats are queued at start
// and popped by a negedge monitor on every handshake.
module tb_reg_dump_reader;

  localparam int N = 5;
  localparam int M = 32;

  typedef struct {
    logic [N-1:0] addr;
    logic [M-1:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] A1;
  logic [M-1:0] RD1;
  logic [N-1:0] dout_addr;
  logic [M-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         done;
  logic [M-1:0] checksum;

  logic [M-1:0] regs [32];
  beat_t        sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           beats = 0;
  int           done_cnt = 0;
  logic [M-1:0] exp_sum;

  assign RD1 = regs[A1];

  always #5 clk = ~clk;

  reg_dump_reader #(.n(N), .m(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo(lo), .hi(hi),
    .A1(A1), .RD1(RD1), .dout_addr(dout_addr), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int a, input int b);
    beat_t bt;
    exp_sum = '0;
    for (int i = a; i <= b; i++) begin
      bt.addr = N'(i);
      bt.data = regs[i];
      sb.push_back(bt);
      exp_sum = exp_sum + regs[i];
    end
  endtask

  function automatic logic [M-1:0] cs_exp(input logic [M-1:0] s);
`ifdef REG_DUMP_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_beat(input int a, input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (dout_valid && dout_addr == N'(a)) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid && dout_ready) begin
      beat_t got;
      beats++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(dout_addr), 64'hFFFF);
      end else begin
        got = sb.pop_front();
        chk("beat_addr", 64'(dout_addr), 64'(got.addr));
        chk("beat_data", 64'(dout), 64'(got.data));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    int cyc;
    int ok;
    int b0;
    for (int i = 0; i < 32; i++) regs[i] = M'(i * 3);
    rst_n = 1'b0; start = 1'b0; lo = '0; hi = '0; dout_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_valid", 64'(dout_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_dout_addr", 64'(dout_addr), 0);
    chk("rst_A1", 64'(A1), 0);
    chk("rst_checksum", 64'(checksum), 0);
    rst_n = 1'b1;
    step();

    // Full dump 0..31 with ready held high
    push_range(0, 31);
    b0 = beats;
    start = 1'b1; lo = 5'd0; hi = 5'd31; dout_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_after_start", 64'(busy), 1);
    chk("t1_valid_in_read", 64'(dout_valid), 0);
    step();
    chk("t1_first_valid", 64'(dout_valid), 1);
    chk("t1_first_addr", 64'(dout_addr), 0);
    wait_done(200, cyc);
    chk("t1_done_latency", 64'(cyc + 1), 64);
    chk("t1_beats", 64'(beats - b0), 32);
    chk("t1_sb_empty", 64'(sb.size()), 0);
    chk("t1_checksum", 64'(checksum), 64'(cs_exp(32'd1488)));
    chk("t1_busy_in_done", 64'(busy), 1);
    step();
    chk("t1_done_pulse_len", 64'(done), 0);
    chk("t1_busy_cleared", 64'(busy), 0);
    chk("t1_checksum_hold", 64'(checksum), 64'(cs_exp(32'd1488)));

    // Single beat with stalls
    push_range(5, 5);
    b0 = beats;
    start = 1'b1; lo = 5'd5; hi = 5'd5; dout_ready = 1'b1;
    step();
    start = 1'b0; dout_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t2_valid_stall", 64'(dout_valid), 1);
      chk("t2_addr_stall", 64'(dout_addr), 5);
      chk("t2_data_stall", 64'(dout), 15);
      chk("t2_A1_stall", 64'(A1), 5);
      if (k < 2) step();
    end
    dout_ready = 1'b1;
    step();
    chk("t2_done", 64'(done), 1);
    chk("t2_beats", 64'(beats - b0), 1);
    chk("t2_checksum", 64'(checksum), 64'(cs_exp(exp_sum)));
    step();

    // Empty range lo > hi
    b0 = beats;
    start = 1'b1; lo = 5'd10; hi = 5'd3;
    step();
    start = 1'b0;
    chk("t3_done", 64'(done), 1);
    chk("t3_busy", 64'(busy), 1);
    chk("t3_valid", 64'(dout_valid), 0);
    chk("t3_checksum", 64'(checksum), 0);
    step();
    chk("t3_done_off", 64'(done), 0);
    chk("t3_valid_after", 64'(dout_valid), 0);
    chk("t3_beats", 64'(beats - b0), 0);

    // Start while busy is ignored
    push_range(0, 31);
    b0 = beats;
    start = 1'b1; lo = 5'd0; hi = 5'd31;
    step();
    start = 1'b0;
    wait_beat(4, 100, ok);
    chk("t4_reach_beat4", 64'(ok), 1);
    start = 1'b1; lo = 5'd20; hi = 5'd21;
    step();
    start = 1'b0;
    wait_done(200, cyc);
    chk("t4_done_seen", 64'(cyc > 0), 1);
    chk("t4_beats", 64'(beats - b0), 32);
    chk("t4_sb_empty", 64'(sb.size()), 0);
    chk("t4_checksum", 64'(checksum), 64'(cs_exp(32'd1488)));
    step();

    // Reset during HOLD at address 7
    push_range(0, 31);
    start = 1'b1; lo = 5'd0; hi = 5'd31;
    step();
    start = 1'b0;
    wait_beat(7, 100, ok);
    chk("t5_reach_beat7", 64'(ok), 1);
    rst_n = 1'b0;
    b0 = done_cnt;
    step();
    chk("t5_pending_dropped", 64'(sb.size()), 25);
    sb.delete();
    chk("t5_valid", 64'(dout_valid), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_done", 64'(done), 0);
    chk("t5_dout", 64'(dout), 0);
    chk("t5_dout_addr", 64'(dout_addr), 0);
    chk("t5_A1", 64'(A1), 0);
    chk("t5_checksum", 64'(checksum), 0);
    rst_n = 1'b1;
    step(); step();
    chk("t5_no_done", 64'(done_cnt - b0), 0);
    push_range(0, 1);
    b0 = beats;
    start = 1'b1; lo = 5'd0; hi = 5'd1;
    step();
    start = 1'b0;
    wait_done(50, cyc);
    chk("t5_after_done", 64'(cyc > 0), 1);
    chk("t5_after_beats", 64'(beats - b0), 2);
    chk("t5_after_checksum", 64'(checksum), 64'(cs_exp(exp_sum)));
    step();

    // Top of address space, no wrap
    push_range(30, 31);
    b0 = beats;
    start = 1'b1; lo = 5'd30; hi = 5'd31;
    step();
    start = 1'b0;
    wait_done(50, cyc);
    chk("t6_done", 64'(cyc), 4);
    chk("t6_beats", 64'(beats - b0), 2);
    chk("t6_sb_empty", 64'(sb.size()), 0);
    chk("t6_A1_end", 64'(A1), 31);
    chk("t6_checksum", 64'(checksum), 64'(cs_exp(exp_sum)));
    step(); step();
    chk("t6_A1_idle", 64'(A1), 31);
    chk("t6_valid_idle", 64'(dout_valid), 0);
    chk("total_done_pulses", 64'(done_cnt), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential reader for the 32-entry register file: on a start pulse it walks a contiguous address range through one read port and streams each (address, data) pair out on a valid/ready channel. It sits beside the register file on a spare read port and feeds the debug/trace path, replacing simulation-only register printing with a synthesizable dump.

## Interface

Parameters:
- n, 5, register address width (2^n registers)
- m, 32, register data width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- lo  in  n  first address to dump; sampled on the accepted start
- hi  in  n  last address to dump, inclusive; sampled on the accepted start
- A1  out  n  read address to the register file read port
- RD1  in  m  read data from the register file; combinational from A1
- dout_addr  out  n  address of the current output beat
- dout  out  m  data of the current output beat
- dout_valid  out  1  output beat valid
- dout_ready  in  1  downstream accepts the beat
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse at the end of a dump
- checksum  out  m  sum of dumped words (see Configuration)

## Operation

- FSM states: IDLE, READ, HOLD, DONE.
- IDLE: busy=0, dout_valid=0. On start=1: latch lo into addr and hi into end. If lo<=hi, go to READ; otherwise go to DONE and emit no beats.
- READ: A1=addr. At the clock edge, capture RD1 into dout and addr into dout_addr, then go to HOLD.
- HOLD: dout_valid=1; dout, dout_addr, and A1 are held stable. On dout_valid&dout_ready: if addr==end, go to DONE; otherwise addr<=addr+1 and go to READ. With dout_ready=0, stay in HOLD indefinitely.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Address compare happens before increment, so hi=2^n-1 never wraps addr to 0.
- start outside IDLE is ignored. It is not queued.
- Data is the register value at the READ cycle. A write to the same address after that cycle is not reflected in the beat.
- A1 equals addr in every state, so it is stable and cheap to route.
- Reset values, in any state: state=IDLE, addr=0, end=0, A1=0, dout=0, dout_addr=0, dout_valid=0, busy=0, done=0, checksum=0.
- Reset mid-dump aborts immediately. No done pulse is produced, and a pending beat is dropped.

## Timing

- Start accepted at edge E0. READ occupies the cycle after E0. dout_valid rises after edge E1, so the first beat is valid two cycles after start.
- Throughput: one beat per 2 cycles when dout_ready is held high.
- A full 32-register dump with ready high takes 64 cycles from start to the last handshake. done asserts on the following cycle.
- done and busy are registered outputs. dout_valid is decoded from state HOLD only.
- The handshake completes on any edge where dout_valid&dout_ready=1. dout_ready may be asserted before valid.

## Configuration

- Macro `REG_DUMP_CHECKSUM_EN`.
- Defined:
  - checksum clears to 0 on accepted start.
  - Each accepted beat adds dout modulo 2^m.
  - The final value is stable from the done pulse until the next accepted start.
- Undefined: the checksum adder is not built and the checksum port is tied to 0.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then regs[i]=i*3; start with lo=0, hi=31, ready=1 → 32 beats, dout_addr 0..31, dout=0,3,..,93 with regs[0] reading 0; done 64 cycles after start. With checksum enabled, checksum=1488.
- lo=5, hi=5, ready toggling 1-0-0-1 → exactly one beat (addr 5), held stable across the stalls, then a done pulse.
- lo=10, hi=3 → no dout_valid, done pulses on the cycle after start, checksum=0.
- start pulsed again while busy at beat 4 of 0..31 → ignored, and the dump completes normally with 32 beats.
- rst_n=0 during HOLD at addr 7 → all outputs are 0 on the next cycle and no done pulse occurs. A subsequent start with lo=0, hi=1 yields exactly 2 beats.
- lo=30, hi=31 → beats at addr 30 and 31 only, no wrap to 0, and A1 ends at 31.
